// File: rtl/cache_core.sv
// Direct-mapped write-back write-allocate data cache, 16-byte lines.
// Define CACHE_PERF_EN to add hit_count/miss_count outputs.
module cache_core #(
   parameter int INDEX_BITS = 9
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         read,
   input  logic         mem_req,
   output logic         hit,
   input  logic [25:0]  paddr,
   input  logic [31:0]  write_data_in,
   output logic [31:0]  read_data_out,
   input  logic [1:0]   access_sz,
   output logic         mc_req_out,
   output logic         mc_read,
   input  logic         mc_ack,
   output logic [25:0]  mc_paddr,
   input  logic [127:0] mc_fill_line,
   output logic [3:0]   mc_writeback_mask,
`ifdef CACHE_PERF_EN
   output logic [127:0] mc_writeback_line,
   output logic [31:0]  hit_count,
   output logic [31:0]  miss_count
`else
   output logic [127:0] mc_writeback_line
`endif
);

   localparam int LINES    = 1 << INDEX_BITS;
   localparam int TAG_BITS = 22 - INDEX_BITS;

   typedef enum logic [1:0] {
      IDLE,
      WB,
      FILL
   } state_t;

   state_t state;

   logic [TAG_BITS-1:0] tag_mem [LINES];
   logic [127:0]        data_mem [LINES];
   logic [LINES-1:0]    valid;
   logic [LINES-1:0][3:0] dirty;

   logic [INDEX_BITS-1:0] idx;
   logic [TAG_BITS-1:0]   tag;
   logic [3:0]            off;
   logic [TAG_BITS-1:0]   cur_tag;
   logic [127:0]          cur_line;
   logic                  lookup_hit;
   logic                  miss;
   logic                  victim_dirty;
   logic                  store_hit;

   assign idx      = paddr[4 +: INDEX_BITS];
   assign tag      = paddr[25 -: TAG_BITS];
   assign off      = paddr[3:0];
   assign cur_tag  = tag_mem[idx];
   assign cur_line = data_mem[idx];

   assign lookup_hit   = valid[idx] && (cur_tag == tag);
   assign hit          = mem_req && (state == IDLE) && lookup_hit;
   assign miss         = mem_req && (state == IDLE) && !lookup_hit;
   assign victim_dirty = valid[idx] && (|dirty[idx]);
   assign store_hit    = hit && !read;

   // Size decode: misaligned low offset bits are dropped.
   logic [3:0]  byte_off;
   logic [15:0] be_base;
   logic [31:0] rmask;

   always_comb begin
      byte_off = {off[3:2], 2'b00};
      be_base  = 16'h000f;
      rmask    = 32'hffff_ffff;
      unique case (1'b1)
         (access_sz == 2'd0): begin
            byte_off = off;
            be_base  = 16'h0001;
            rmask    = 32'h0000_00ff;
         end
         (access_sz == 2'd1): begin
            byte_off = {off[3:1], 1'b0};
            be_base  = 16'h0003;
            rmask    = 32'h0000_ffff;
         end
         default: begin
            byte_off = {off[3:2], 2'b00};
            be_base  = 16'h000f;
            rmask    = 32'hffff_ffff;
         end
      endcase
   end

   logic [6:0]   bit_sh;
   logic [127:0] rd_shift;
   logic [15:0]  be;
   logic [127:0] wr_line;
   logic [127:0] bit_mask;
   logic [127:0] merged;

   assign bit_sh   = {byte_off, 3'b000};
   assign rd_shift = cur_line >> bit_sh;
   assign be       = be_base << byte_off;
   assign wr_line  = {96'd0, write_data_in} << bit_sh;

   assign read_data_out = hit ? (rd_shift[31:0] & rmask) : 32'd0;

   always_comb begin
      bit_mask = '0;
      for (int b = 0; b < 16; b++) begin
         bit_mask[b*8 +: 8] = {8{be[b]}};
      end
   end

   assign merged = (cur_line & ~bit_mask) | (wr_line & bit_mask);

   // Line storage carries no reset; valid gates every use.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (store_hit) begin
            data_mem[idx] <= merged;
         end else if (state == FILL && mc_ack) begin
            data_mem[idx] <= mc_fill_line;
            tag_mem[idx]  <= tag;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state             <= IDLE;
         valid             <= '0;
         dirty             <= '0;
         mc_req_out        <= 1'b0;
         mc_read           <= 1'b1;
         mc_paddr          <= '0;
         mc_writeback_mask <= '0;
         mc_writeback_line <= '0;
      end else begin
         mc_req_out <= 1'b0;
         unique case (state)
            IDLE: begin
               if (store_hit) begin
                  dirty[idx][off[3:2]] <= 1'b1;
               end else if (miss) begin
                  mc_req_out <= 1'b1;
                  if (victim_dirty) begin
                     state             <= WB;
                     mc_read           <= 1'b0;
                     mc_paddr          <= {cur_tag, idx, 4'b0000};
                     mc_writeback_mask <= dirty[idx];
                     mc_writeback_line <= cur_line;
                  end else begin
                     state    <= FILL;
                     mc_read  <= 1'b1;
                     mc_paddr <= {paddr[25:4], 4'b0000};
                  end
               end
            end
            WB: begin
               if (mc_ack) begin
                  state      <= FILL;
                  mc_req_out <= 1'b1;
                  mc_read    <= 1'b1;
                  mc_paddr   <= {paddr[25:4], 4'b0000};
               end
            end
            FILL: begin
               if (mc_ack) begin
                  state      <= IDLE;
                  valid[idx] <= 1'b1;
                  dirty[idx] <= 4'b0000;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef CACHE_PERF_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         hit_count  <= '0;
         miss_count <= '0;
      end else begin
         if (hit) begin
            hit_count <= hit_count + 32'd1;
         end
         if (miss) begin
            miss_count <= miss_count + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_cache_core.sv
// Scoreboard bench for cache_core: queued expected memory-controller
// transactions and load data, popped when the DUT produces them.
module tb_cache_core;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         read = 1'b1;
   logic         mem_req = 1'b0;
   logic         hit;
   logic [25:0]  paddr = '0;
   logic [31:0]  write_data_in = '0;
   logic [31:0]  read_data_out;
   logic [1:0]   access_sz = 2'd2;
   logic         mc_req_out;
   logic         mc_read;
   logic         mc_ack = 1'b0;
   logic [25:0]  mc_paddr;
   logic [127:0] mc_fill_line = '0;
   logic [3:0]   mc_writeback_mask;
   logic [127:0] mc_writeback_line;
`ifdef CACHE_PERF_EN
   logic [31:0]  hit_count;
   logic [31:0]  miss_count;
`endif

   cache_core dut (
      .clk               (clk),
      .rst               (rst),
      .read              (read),
      .mem_req           (mem_req),
      .hit               (hit),
      .paddr             (paddr),
      .write_data_in     (write_data_in),
      .read_data_out     (read_data_out),
      .access_sz         (access_sz),
      .mc_req_out        (mc_req_out),
      .mc_read           (mc_read),
      .mc_ack            (mc_ack),
      .mc_paddr          (mc_paddr),
      .mc_fill_line      (mc_fill_line),
      .mc_writeback_mask (mc_writeback_mask),
`ifdef CACHE_PERF_EN
      .mc_writeback_line (mc_writeback_line),
      .hit_count         (hit_count),
      .miss_count        (miss_count)
`else
      .mc_writeback_line (mc_writeback_line)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic         rd;
      logic [25:0]  pa;
      logic [3:0]   mask;
      logic [127:0] line;
   } mc_t;

   mc_t          exp_mc [$];
   logic [31:0]  exp_rd [$];
   logic [127:0] mem [logic [21:0]];

   function automatic logic [127:0] mem_line(input logic [21:0] k);
      if (mem.exists(k)) return mem[k];
      return '0;
   endfunction

   task automatic push_fill(input logic [25:0] pa);
      mc_t t;
      t.rd = 1'b1; t.pa = pa; t.mask = '0; t.line = '0;
      exp_mc.push_back(t);
   endtask

   task automatic push_wb(input logic [25:0] pa, input logic [3:0] m,
                          input logic [127:0] l);
      mc_t t;
      t.rd = 1'b0; t.pa = pa; t.mask = m; t.line = l;
      exp_mc.push_back(t);
   endtask

   // One CPU access held until hit, with the memory controller modelled inline.
   task automatic access(input logic rd, input logic [25:0] a,
                         input logic [1:0] sz, input logic [31:0] wd,
                         input logic exp_miss, input string nm);
      int   ack_wait;
      logic req_prev;
      bit   done;
      mc_t  t;
      logic [31:0]  e;
      logic [127:0] m;
      ack_wait = 0; req_prev = 1'b0; done = 0;
      read = rd; paddr = a; access_sz = sz; write_data_in = wd; mem_req = 1'b1;
      for (int cyc = 0; cyc < 100 && !done; cyc++) begin
         @(negedge clk);
         if (cyc == 0 && exp_miss) begin
            checks++;
            if (hit !== 1'b0 || read_data_out !== 32'd0) begin
               errors++;
               $display("FAIL %s miss_cycle hit=%b rdata=%h required hit=0 rdata=0",
                        nm, hit, read_data_out);
            end
         end
         if (mc_ack) mc_ack = 1'b0;
         if (req_prev) begin
            checks++;
            if (mc_req_out !== 1'b0) begin
               errors++;
               $display("FAIL %s req_pulse mc_req_out=%b required 0", nm, mc_req_out);
            end
         end
         req_prev = mc_req_out;
         if (ack_wait > 0) begin
            ack_wait--;
            if (ack_wait == 0) mc_ack = 1'b1;
         end
         if (mc_req_out) begin
            checks++;
            if (exp_mc.size() == 0) begin
               errors++;
               $display("FAIL %s unexpected_mc rd=%b pa=%h required none",
                        nm, mc_read, mc_paddr);
            end else begin
               t = exp_mc.pop_front();
               if (mc_read !== t.rd || mc_paddr !== t.pa ||
                   (!t.rd && (mc_writeback_mask !== t.mask ||
                              mc_writeback_line !== t.line))) begin
                  errors++;
                  $display("FAIL %s mc_txn got rd=%b pa=%h mask=%h line=%h required rd=%b pa=%h mask=%h line=%h",
                           nm, mc_read, mc_paddr, mc_writeback_mask,
                           mc_writeback_line, t.rd, t.pa, t.mask, t.line);
               end
            end
            if (mc_read) begin
               mc_fill_line = mem_line(mc_paddr[25:4]);
            end else begin
               m = mem_line(mc_paddr[25:4]);
               for (int w = 0; w < 4; w++)
                  if (mc_writeback_mask[w]) m[w*32 +: 32] = mc_writeback_line[w*32 +: 32];
               mem[mc_paddr[25:4]] = m;
            end
            ack_wait = 2;
         end
         if (hit) begin
            done = 1;
            if (rd) begin
               checks++;
               if (exp_rd.size() == 0) begin
                  errors++;
                  $display("FAIL %s no_expected_load got=%h", nm, read_data_out);
               end else begin
                  e = exp_rd.pop_front();
                  if (read_data_out !== e) begin
                     errors++;
                     $display("FAIL %s load_data got=%h required=%h", nm, read_data_out, e);
                  end
               end
            end
         end
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL %s timeout hit=0 required hit=1", nm);
      end
      @(posedge clk);
      #1;
      mem_req = 1'b0;
      mc_ack = 1'b0;
      checks++;
      if (exp_mc.size() != 0) begin
         errors++;
         $display("FAIL %s missing_mc got=%0d pending required 0", nm, exp_mc.size());
      end
      exp_mc.delete();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (hit !== 1'b0) begin
         errors++; $display("FAIL rst_hit got=%b required=0", hit);
      end
      checks++;
      if (mc_req_out !== 1'b0) begin
         errors++; $display("FAIL rst_req got=%b required=0", mc_req_out);
      end
      checks++;
      if (mc_read !== 1'b1) begin
         errors++; $display("FAIL rst_mc_read got=%b required=1", mc_read);
      end
      checks++;
      if (mc_paddr !== 26'd0) begin
         errors++; $display("FAIL rst_paddr got=%h required=0", mc_paddr);
      end
      checks++;
      if (mc_writeback_mask !== 4'd0 || mc_writeback_line !== 128'd0) begin
         errors++;
         $display("FAIL rst_wb got mask=%h line=%h required 0", mc_writeback_mask,
                  mc_writeback_line);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_fill_hit();
      push_fill(26'h0);
      exp_rd.push_back(32'd0);
      access(1'b1, 26'h0, 2'd2, 32'd0, 1'b1, "fill_ld0");
   endtask

   task automatic test_stores();
      for (int i = 0; i < 8; i++) begin
         if (i == 4) push_fill(26'h10);
         access(1'b0, 26'(4 * i), 2'd2, 32'(i), (i == 4), "store_word");
      end
   endtask

   task automatic test_writeback();
      push_wb(26'h0, 4'hf, {32'd3, 32'd2, 32'd1, 32'd0});
      push_fill(26'h2000);
      exp_rd.push_back(32'h0000_00a0);
      access(1'b1, 26'h2000, 2'd2, 32'd0, 1'b1, "wb_ld2000");
   endtask

   task automatic test_reload();
      push_fill(26'h0);
      for (int i = 0; i < 8; i++) begin
         exp_rd.push_back(32'(i));
         access(1'b1, 26'(4 * i), 2'd2, 32'd0, (i == 0), "reload");
      end
   endtask

   task automatic test_halfword();
      access(1'b0, 26'h6, 2'd1, 32'hffff_abcd, 1'b0, "st_half6");
      exp_rd.push_back(32'h0000_00ab);
      access(1'b1, 26'h7, 2'd0, 32'd0, 1'b0, "ld_byte7");
      exp_rd.push_back(32'h0000_00cd);
      access(1'b1, 26'h6, 2'd0, 32'd0, 1'b0, "ld_byte6");
      exp_rd.push_back(32'h0000_abcd);
      access(1'b1, 26'h7, 2'd1, 32'd0, 1'b0, "ld_half7");
      exp_rd.push_back(32'habcd_0001);
      access(1'b1, 26'h6, 2'd3, 32'd0, 1'b0, "ld_sz3_6");
      exp_rd.push_back(32'h0000_0003);
      access(1'b1, 26'hc, 2'd0, 32'd0, 1'b0, "ld_byte_c");
      push_wb(26'h0, 4'h2, {32'd3, 32'd2, 32'habcd_0001, 32'd0});
      push_fill(26'h2000);
      exp_rd.push_back(32'h0000_00a1);
      access(1'b1, 26'h2004, 2'd2, 32'd0, 1'b1, "wb_half");
   endtask

   task automatic test_reset_in_fill();
      bit seen;
      seen = 0;
      read = 1'b1; paddr = 26'h4000; access_sz = 2'd2; mem_req = 1'b1;
      for (int cyc = 0; cyc < 10 && !seen; cyc++) begin
         @(negedge clk);
         if (mc_req_out) seen = 1;
      end
      checks++;
      if (!seen || mc_read !== 1'b1 || mc_paddr !== 26'h4000) begin
         errors++;
         $display("FAIL rif_req seen=%0d rd=%b pa=%h required seen=1 rd=1 pa=4000",
                  seen, mc_read, mc_paddr);
      end
      @(posedge clk);
      #1;
      mem_req = 1'b0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if (mc_req_out !== 1'b0 || hit !== 1'b0) begin
         errors++;
         $display("FAIL rif_in_reset req=%b hit=%b required 0 0", mc_req_out, hit);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      mc_ack = 1'b1;
      @(negedge clk);
      mc_ack = 1'b0;
      seen = 0;
      repeat (3) begin
         @(negedge clk);
         if (mc_req_out !== 1'b0) seen = 1;
      end
      checks++;
      if (seen) begin
         errors++;
         $display("FAIL rif_late_ack mc_req_out=1 required 0");
      end
      push_fill(26'h0);
      exp_rd.push_back(32'd0);
      access(1'b1, 26'h0, 2'd2, 32'd0, 1'b1, "rif_reaccess");
   endtask

   initial begin
      mem[22'h0]   = {32'd3, 32'd2, 32'd1, 32'd0};
      mem[22'h1]   = 128'h11111111_22222222_33333333_44444444;
      mem[22'h200] = {32'ha3, 32'ha2, 32'ha1, 32'ha0};
      test_reset();
      test_fill_hit();
      test_stores();
      test_writeback();
      test_reload();
      test_halfword();
      test_reset_in_fill();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
